// File: rtl/capture_config_controller.sv
// Front-panel configuration controller for the logic analyzer: turns button levels
// into registered rate, channel and per-channel trigger settings, with rate auto-repeat.
module capture_config_controller #(
    parameter int N_CHANNELS       = 16,
    parameter int CLK_FREQ         = 50_000_000,
    parameter int PRESC_W          = 29,
    parameter int MAX_RATE_INDEX   = 20,
    parameter int RESET_RATE_INDEX = 0,
    parameter int HOLD_CYCLES      = 25_000_000,
    parameter int REPEAT_CYCLES    = 5_000_000,
    localparam int RW = $clog2(MAX_RATE_INDEX + 1),
    localparam int CW = $clog2(N_CHANNELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               faster,
    input  logic               slower,
    input  logic               chan_next,
    input  logic               chan_prev,
    input  logic               trig_toggle,
    input  logic               trig_clear,
    input  logic               lock,
    output logic [PRESC_W-1:0] PRESCALING_FACTOR,
    output logic [PRESC_W-1:0] SAMPLING_FREQUENCY,
    output logic [RW-1:0]      RATE_INDEX,
    output logic [CW-1:0]      SELECTED_CHANNEL,
    output logic [1:0]         TRIGGER_KIND [N_CHANNELS],
    output logic               CONFIG_CHANGED
);

    localparam int MAX_CNT = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0]   HOLD_C  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   REP_C   = CNT_W'(REPEAT_CYCLES);
    localparam logic [RW-1:0]      MAX_IDX = RW'(MAX_RATE_INDEX);
    localparam logic [RW-1:0]      RST_IDX = RW'(RESET_RATE_INDEX);
    localparam logic [CW-1:0]      LAST_CH = CW'(N_CHANNELS - 1);
    localparam logic [PRESC_W-1:0] ONE     = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] CLK_F   = PRESC_W'(CLK_FREQ);

    // Bit order: 0 faster, 1 slower, 2 chan_next, 3 chan_prev, 4 trig_toggle, 5 trig_clear.
    logic [5:0] btn;
    logic [5:0] btn_q;
    logic [5:0] press;

    // Per rate button: cycles since press (0 = idle) and whether the hold phase has ended.
    logic [CNT_W-1:0] rep_cnt [2];
    logic [1:0]       repeating;
    logic [1:0]       rep_fire;
    logic [1:0]       rate_step;

    logic [RW-1:0] idx_n;
    logic [CW-1:0] chan_n;
    logic [1:0]    trig_n [N_CHANNELS];
    logic          changed;

    assign btn   = {trig_clear, trig_toggle, chan_prev, chan_next, slower, faster};
    assign press = btn & ~btn_q & {6{~lock}};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rep_fire[i]  = (rep_cnt[i] != '0) && btn[i] &&
                           (rep_cnt[i] == (repeating[i] ? REP_C : HOLD_C));
            rate_step[i] = ~lock & (press[i] | rep_fire[i]);
        end

        // Opposite rate steps in the same cycle cancel out.
        idx_n = RATE_INDEX;
        if (rate_step == 2'b01 && RATE_INDEX != '0)
            idx_n = RATE_INDEX - RW'(1);
        else if (rate_step == 2'b10 && RATE_INDEX != MAX_IDX)
            idx_n = RATE_INDEX + RW'(1);

        chan_n = SELECTED_CHANNEL;
        if (press[2] && !press[3])
            chan_n = (SELECTED_CHANNEL == LAST_CH) ? '0 : SELECTED_CHANNEL + CW'(1);
        else if (press[3] && !press[2])
            chan_n = (SELECTED_CHANNEL == '0) ? LAST_CH : SELECTED_CHANNEL - CW'(1);

        changed = (idx_n != RATE_INDEX) || (chan_n != SELECTED_CHANNEL);
        for (int i = 0; i < N_CHANNELS; i++) begin
            trig_n[i] = TRIGGER_KIND[i];
            if (press[5])
                trig_n[i] = 2'd0;
            else if (press[4] && SELECTED_CHANNEL == CW'(i))
                trig_n[i] = TRIGGER_KIND[i] + 2'd1;
            changed = changed || (trig_n[i] != TRIGGER_KIND[i]);
        end
    end

    always_ff @(posedge clk) begin
        btn_q <= btn;
        if (rst) begin
            RATE_INDEX         <= RST_IDX;
            PRESCALING_FACTOR  <= ONE << RST_IDX;
            SAMPLING_FREQUENCY <= CLK_F >> RST_IDX;
            SELECTED_CHANNEL   <= '0;
            for (int i = 0; i < N_CHANNELS; i++)
                TRIGGER_KIND[i] <= 2'd0;
            CONFIG_CHANGED     <= 1'b0;
            for (int i = 0; i < 2; i++)
                rep_cnt[i] <= '0;
            repeating          <= 2'b00;
        end else begin
            RATE_INDEX         <= idx_n;
            PRESCALING_FACTOR  <= ONE << idx_n;
            SAMPLING_FREQUENCY <= CLK_F >> idx_n;
            SELECTED_CHANNEL   <= chan_n;
            TRIGGER_KIND       <= trig_n;
            CONFIG_CHANGED     <= changed;
            for (int i = 0; i < 2; i++) begin
                if (lock || !btn[i] || press[i ^ 1]) begin
                    rep_cnt[i]   <= '0;
                    repeating[i] <= 1'b0;
                end else if (press[i]) begin
                    rep_cnt[i]   <= CNT_W'(1);
                    repeating[i] <= 1'b0;
                end else if (rep_cnt[i] != '0) begin
                    if (rep_fire[i]) begin
                        rep_cnt[i]   <= CNT_W'(1);
                        repeating[i] <= 1'b1;
                    end else begin
                        rep_cnt[i] <= rep_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
